manchester_rx_recover: RTL
==========================

// Module: manchester_rx_recover
// PURPOSE
//  Receive-side stage directly downstream of the Manchester serializer: oversamples serial_in on aclk.
//  Recovers bit timing from mid-bit transitions and locks on the preamble training pattern.
//  Finds SYNC_WORD, then assembles MSB-first bytes onto an AXI-Stream master (tdata/tvalid/tready/tlast).
//  Frame end = line idle; the last byte before idle carries tlast. Output feeds the unescape/deframe stages.
// PARAMETERS
//  HALF_BIT_CLKS  4      aclk cycles per Manchester half-bit (>=4, even)
//  LOCK_EDGES     8      consecutive 2H-spaced edges required to declare lock
//  SYNC_WORD      8'hD5  byte ending the preamble; first data byte follows it
// PORTS
//  aclk           in   1  single clock, all logic rising-edge
//  aresetn        in   1  asynchronous active-low reset
//  serial_in      in   1  Manchester line, asynchronous to aclk
//  m_axis_tdata   out  8  received byte
//  m_axis_tvalid  out  1  byte valid
//  m_axis_tready  in   1  downstream accept
//  m_axis_tlast   out  1  last byte of frame
//  locked         out  1  high in SYNC and DATA states
//  overflow       out  1  one-cycle pulse: byte dropped due to backpressure
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timer 0, shift/hold registers 0; applied async, released on aclk.
//  Input: 2-FF synchronizer then edge detect; edge seen 3 cycles after pin. H=HALF_BIT_CLKS.
//  Coding: '1' = low->high at mid-bit, '0' = high->low; MSB first. Timer counts aclk since last mid-bit edge,
//   saturates at 4H; width $clog2(4H+1).
//  Edge classification (timer value t at edge): t<H/2 glitch -> code violation; H/2<=t<3H/2 boundary edge,
//   ignored, timer not reset; 3H/2<=t<=5H/2 mid-bit edge -> bit=new level, timer<=0; t>5H/2 violation.
//  Idle: t reaches 3H with no mid-bit edge -> frame end.
//  FSM: IDLE -(any edge, timer<=0)-> HUNT: each edge with t in [3H/2,5H/2] increments lock count, else count<=0;
//   count==LOCK_EDGES -> SYNC. SYNC: shift decoded bits into 8-bit window; window==SYNC_WORD -> DATA, bitcnt<=0.
//   DATA: every 8 bits -> new byte. Any violation or idle in HUNT/SYNC/DATA -> IDLE.
//  Output: one-byte hold register. Completed byte goes to hold; previous hold content is presented with tlast=0.
//   On idle in DATA, held byte presented with tlast=1. Idle/violation in SYNC/HUNT emits nothing.
//  Violation in DATA: held byte presented with tlast=1; partial byte discarded.
//  AXIS: tvalid stays high with tdata/tlast stable until tready; transfer on tvalid&tready. Byte-to-tvalid
//   latency 1 cycle after hold slot frees.
//  Backpressure: byte completes while output slot and hold both full -> new byte dropped, overflow pulses 1 cycle,
//   state unaffected. Completion coinciding with output handshake is NOT overflow.
//  A single byte between SYNC_WORD and idle is emitted with tlast=1. Reset mid-frame discards everything, no tlast.
// CONFIGURATION
//  MANCHESTER_RX_ERR_CNT_EN defined: adds output code_err_cnt[15:0] = count of code violations
//   (glitch, t>5H/2), saturating at 16'hFFFF, cleared only by reset.
//   Undefined: port and counter absent; violations still force IDLE.
// STRUCTURE
//  Package manchester_rx_pkg: state enum (IDLE,HUNT,SYNC,DATA), coding polarity constants, timer-threshold
//   functions of H.
//  Sub-module manchester_edge_timer: synchronizer, edge detect, timer, edge classification
//   (mid/boundary/violation/idle strobes).
//  Top: FSM, shift/bit counter, hold register, AXIS output.
// TESTING (H=4)
//  Loopback from sender chain: 0x55 x4, D5, bytes 01..10, idle -> 16 bytes 01..10 in order, tlast only on 0x10.
//  Only 0x55 x4 then idle -> locked rises after 8 edges, falls on idle; no tvalid.
//  Frame 0x55 x2, D5, A5, 3C with tready=0 until idle+20 -> 0xA5 tlast=0 held, 0x3C dropped, overflow=1 once.
//  1-cycle glitch mid-byte in DATA -> IDLE, locked=0, held byte out with tlast=1, err_cnt=1 if _EN.
//  Edge spacing 7 then 9 cycles (jitter +/-1) over full frame -> all bytes correct, no violations.
//  aresetn low mid-byte -> tvalid=0 in same cycle, next frame received intact.

Source files
------------

// File: rtl/manchester_rx_pkg.sv
// Shared types and timing thresholds for the Manchester receive path.
// Thresholds are expressed as functions of the half-bit length H in aclk cycles.
package manchester_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    SYNC,
    DATA
  } rx_state_e;

  // Decoded bit value carried by each mid-bit transition direction
  localparam logic RISE_BIT = 1'b1;
  localparam logic FALL_BIT = 1'b0;

  function automatic int unsigned timer_width(input int unsigned h);
    return $clog2(4 * h + 1);
  endfunction

  function automatic int unsigned glitch_lim(input int unsigned h);
    return h / 2;
  endfunction

  function automatic int unsigned mid_lo(input int unsigned h);
    return (3 * h) / 2;
  endfunction

  function automatic int unsigned mid_hi(input int unsigned h);
    return (5 * h) / 2;
  endfunction

  function automatic int unsigned idle_lim(input int unsigned h);
    return 3 * h;
  endfunction

  function automatic int unsigned sat_lim(input int unsigned h);
    return 4 * h;
  endfunction

endpackage

// File: rtl/manchester_rx_recover_edge_timer.sv
// Line synchronizer, edge detector and inter-edge timer for the Manchester receiver.
// Classifies each edge as glitch/boundary/mid-bit/late and flags line idle.
module manchester_edge_timer
  import manchester_rx_pkg::*;
#(
  parameter int unsigned HALF_BIT_CLKS = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_serial,
  input  logic i_clr,
  output logic o_edge,
  output logic o_mid,
  output logic o_boundary,
  output logic o_violation,
  output logic o_idle,
  output logic o_bit
);

  localparam int unsigned TW = timer_width(HALF_BIT_CLKS);
  localparam logic [TW-1:0] T_GLITCH = TW'(glitch_lim(HALF_BIT_CLKS));
  localparam logic [TW-1:0] T_MID_LO = TW'(mid_lo(HALF_BIT_CLKS));
  localparam logic [TW-1:0] T_MID_HI = TW'(mid_hi(HALF_BIT_CLKS));
  localparam logic [TW-1:0] T_IDLE   = TW'(idle_lim(HALF_BIT_CLKS));
  localparam logic [TW-1:0] T_SAT    = TW'(sat_lim(HALF_BIT_CLKS));

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [TW-1:0] r_timer;
  logic          w_edge;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_serial;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_prev;

  always_comb begin
    o_mid       = 1'b0;
    o_boundary  = 1'b0;
    o_violation = 1'b0;
    if (w_edge) begin
      if (r_timer < T_GLITCH) begin
        o_violation = 1'b1;
      end else if (r_timer < T_MID_LO) begin
        o_boundary = 1'b1;
      end else if (r_timer <= T_MID_HI) begin
        o_mid = 1'b1;
      end else begin
        o_violation = 1'b1;
      end
    end
  end

  // Boundary edges deliberately leave the timer running: it measures mid-to-mid spacing
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timer <= '0;
    end else if (i_clr || o_mid) begin
      r_timer <= '0;
    end else if (r_timer != T_SAT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_edge = w_edge;
  assign o_idle = !w_edge && (r_timer == T_IDLE);
  assign o_bit  = r_sync2 ? RISE_BIT : FALL_BIT;

endmodule

// File: rtl/manchester_rx_recover.sv
// Manchester receiver: preamble lock, sync-word search, MSB-first byte assembly onto AXI-Stream.
// Optional MANCHESTER_RX_ERR_CNT_EN adds a saturating code-violation counter output.
module manchester_rx_recover
  import manchester_rx_pkg::*;
#(
  parameter int unsigned HALF_BIT_CLKS = 4,
  parameter int unsigned LOCK_EDGES    = 8,
  parameter logic [7:0]  SYNC_WORD     = 8'hD5
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       serial_in,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       locked,
  output logic       overflow
`ifdef MANCHESTER_RX_ERR_CNT_EN
  ,
  output logic [15:0] code_err_cnt
`endif
);

  localparam int unsigned LCW = $clog2(LOCK_EDGES + 1);
  localparam logic [LCW-1:0] LOCK_N = LCW'(LOCK_EDGES);

  rx_state_e      r_state;
  rx_state_e      w_state_nxt;
  logic [LCW-1:0] r_lock_cnt;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;
  logic [7:0]     r_hold;
  logic           r_hold_vld;
  logic [7:0]     r_tdata;
  logic           r_tvalid;
  logic           r_tlast;
  logic           r_overflow;

  logic       w_edge;
  logic       w_mid;
  logic       w_boundary;
  logic       w_violation;
  logic       w_idle;
  logic       w_bit;
  logic [7:0] w_shift_nxt;
  logic       w_byte_done;
  logic       w_flush;
  logic       w_out_free;

  manchester_edge_timer #(
    .HALF_BIT_CLKS(HALF_BIT_CLKS)
  ) u_edge_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_serial   (serial_in),
    .i_clr      ((r_state == IDLE) && w_edge),
    .o_edge     (w_edge),
    .o_mid      (w_mid),
    .o_boundary (w_boundary),
    .o_violation(w_violation),
    .o_idle     (w_idle),
    .o_bit      (w_bit)
  );

  assign w_shift_nxt = {r_shift[6:0], w_bit};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_done = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) w_state_nxt = HUNT;
      end
      HUNT: begin
        if (w_violation || w_idle) begin
          w_state_nxt = IDLE;
        end else if (r_lock_cnt == LOCK_N) begin
          w_state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (w_violation || w_idle) begin
          w_state_nxt = IDLE;
        end else if (w_mid && (w_shift_nxt == SYNC_WORD)) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_violation || w_idle) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (w_mid && (r_bitcnt == 3'd7)) begin
          w_byte_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_lock_cnt <= '0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
    end else begin
      if (r_state != HUNT) begin
        r_lock_cnt <= '0;
      end else if (w_mid && (r_lock_cnt != LOCK_N)) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end else if (w_boundary) begin
        r_lock_cnt <= '0;
      end

      // One register serves as the sync-word window in SYNC and the byte assembler in DATA
      if ((r_state == IDLE) || (r_state == HUNT)) begin
        r_shift <= '0;
      end else if (w_mid) begin
        r_shift <= w_shift_nxt;
      end

      if (r_state != DATA) begin
        r_bitcnt <= '0;
      end else if (w_mid) begin
        r_bitcnt <= r_bitcnt + 1'b1;
      end
    end
  end

  assign w_out_free = !r_tvalid || m_axis_tready;

  // A byte sits in hold until the next byte or the frame end decides its tlast
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_byte_done) begin
        if (!r_hold_vld) begin
          r_hold     <= w_shift_nxt;
          r_hold_vld <= 1'b1;
        end else if (w_out_free) begin
          r_tdata  <= r_hold;
          r_tlast  <= 1'b0;
          r_tvalid <= 1'b1;
          r_hold   <= w_shift_nxt;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_flush && r_hold_vld) begin
        if (w_out_free) begin
          r_tdata  <= r_hold;
          r_tlast  <= 1'b1;
          r_tvalid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
        r_hold     <= '0;
        r_hold_vld <= 1'b0;
      end
    end
  end

`ifdef MANCHESTER_RX_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_cnt <= '0;
    end else if (w_violation && (r_state != IDLE) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign code_err_cnt = r_err_cnt;
`endif

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign overflow      = r_overflow;
  assign locked        = (r_state == SYNC) || (r_state == DATA);

endmodule
